// File: rtl/prog_loader.sv
// Program-mode loader for the SAP RAM: debounced write/wipe buttons drive a
// registered RAM write port; the CPU is held in clear outside run mode.
module prog_loader #(
  parameter int unsigned ADDR_W          = 4,
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              prog_run,
  input  logic              auto_inc,
  input  logic              botao_write,
  input  logic              botao_wipe,
  input  logic [ADDR_W-1:0] switch_enderecos,
  input  logic [DATA_W-1:0] switch_dados,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic [ADDR_W-1:0] addr_count
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] SWEEP_LAST = '1;

  typedef enum logic [2:0] {
    S_RUN,
    S_IDLE,
    S_DEBOUNCE,
    S_WRITE,
    S_WIPE,
    S_RELEASE
  } state_e;

  logic [1:0] run_sync_q;
  logic [1:0] wr_sync_q;
  logic [1:0] wp_sync_q;
  logic       run_s;
  logic       write_s;
  logic       wipe_s;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   sweep_q, sweep_d;
  logic                req_wipe_q, req_wipe_d;
  logic                auto_q, auto_d;
  logic [ADDR_W-1:0]   addr_count_q, addr_count_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_data_q, ram_data_d;
  logic                ram_we_q, ram_we_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                busy_q, busy_d;
  logic                req_low;

  // Two-flop synchronizers; reset loads the inactive levels.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      run_sync_q <= 2'b00;
      wr_sync_q  <= 2'b11;
      wp_sync_q  <= 2'b11;
    end else begin
      run_sync_q <= {run_sync_q[0], prog_run};
      wr_sync_q  <= {wr_sync_q[0], botao_write};
      wp_sync_q  <= {wp_sync_q[0], botao_wipe};
    end
  end

  assign run_s   = run_sync_q[1];
  assign write_s = wr_sync_q[1];
  assign wipe_s  = wp_sync_q[1];

  // State, counters and the registered RAM-port outputs.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sweep_q      <= '0;
      req_wipe_q   <= 1'b0;
      auto_q       <= 1'b0;
      addr_count_q <= '0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      ram_we_q     <= 1'b0;
      cpu_hold_q   <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sweep_q      <= sweep_d;
      req_wipe_q   <= req_wipe_d;
      auto_q       <= auto_d;
      addr_count_q <= addr_count_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      ram_we_q     <= ram_we_d;
      cpu_hold_q   <= cpu_hold_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they line up
  // with the state register.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sweep_d      = sweep_q;
    req_wipe_d   = req_wipe_q;
    auto_d       = auto_q;
    addr_count_d = addr_count_q;
    req_low      = req_wipe_q ? !wipe_s : !write_s;

    case (state_q)
      S_RUN: begin
        if (!run_s) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (run_s) begin
          state_d = S_RUN;
        end else if (!write_s || !wipe_s) begin
          state_d    = S_DEBOUNCE;
          cnt_d      = '0;
          req_wipe_d = write_s;
        end
      end
      S_DEBOUNCE: begin
        if (run_s) begin
          state_d = S_RUN;
        end else if (!req_low) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          if (req_wipe_q) begin
            state_d = S_WIPE;
            sweep_d = '0;
          end else begin
            state_d = S_WRITE;
            auto_d  = auto_inc;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WRITE: begin
        state_d = S_RELEASE;
        cnt_d   = '0;
        if (auto_q) begin
          addr_count_d = addr_count_q + ADDR_W'(1);
        end
      end
      S_WIPE: begin
        if (sweep_q == SWEEP_LAST) begin
          state_d      = S_RELEASE;
          cnt_d        = '0;
          addr_count_d = '0;
        end else begin
          sweep_d = sweep_q + ADDR_W'(1);
        end
      end
      S_RELEASE: begin
        if (run_s) begin
          state_d = S_RUN;
        end else if (write_s && wipe_s) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ram_we_d   = 1'b0;
    busy_d     = 1'b0;
    ram_data_d = '0;
    ram_addr_d = addr_count_d;
    cpu_hold_d = (state_d != S_RUN);

    case (state_d)
      S_WRITE: begin
        ram_we_d   = 1'b1;
        busy_d     = 1'b1;
        ram_data_d = switch_dados;
        ram_addr_d = auto_inc ? addr_count_q : switch_enderecos;
      end
      S_WIPE: begin
        ram_we_d   = 1'b1;
        busy_d     = 1'b1;
        ram_addr_d = sweep_d;
      end
      default: ;
    endcase
  end

  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign ram_we     = ram_we_q;
  assign cpu_hold   = cpu_hold_q;
  assign busy       = busy_q;
  assign addr_count = addr_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with DEBOUNCE_CYCLES = 4; a negedge monitor
// records every RAM write strobe for later checking.
module tb_prog_loader;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEB    = 4;

  logic              clock = 1'b0;
  logic              clear_n;
  logic              prog_run;
  logic              auto_inc;
  logic              botao_write;
  logic              botao_wipe;
  logic [ADDR_W-1:0] switch_enderecos;
  logic [DATA_W-1:0] switch_dados;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_we;
  logic              cpu_hold;
  logic              busy;
  logic [ADDR_W-1:0] addr_count;

  prog_loader #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock           (clock),
    .clear_n         (clear_n),
    .prog_run        (prog_run),
    .auto_inc        (auto_inc),
    .botao_write     (botao_write),
    .botao_wipe      (botao_wipe),
    .switch_enderecos(switch_enderecos),
    .switch_dados    (switch_dados),
    .ram_addr        (ram_addr),
    .ram_data        (ram_data),
    .ram_we          (ram_we),
    .cpu_hold        (cpu_hold),
    .busy            (busy),
    .addr_count      (addr_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [ADDR_W+DATA_W-1:0] wr_q[$];
  int run_q[$];
  int run_len   = 0;
  int busy_bad  = 0;

  // Write-strobe monitor, sampled on the falling edge.
  always @(negedge clock) begin
    if (ram_we === 1'b1) begin
      wr_q.push_back({ram_addr, ram_data});
      run_len = run_len + 1;
      if (busy !== 1'b1) busy_bad = busy_bad + 1;
    end else begin
      if (run_len > 0) run_q.push_back(run_len);
      run_len = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press(input bit wipe, input int hold, input int rel);
    if (wipe) botao_wipe = 1'b0;
    else      botao_write = 1'b0;
    step(hold);
    botao_wipe  = 1'b1;
    botao_write = 1'b1;
    step(rel);
  endtask

  int base;
  int rbase;
  int bb;
  int first;
  logic [ADDR_W+DATA_W-1:0] ent;

  initial begin
    clear_n          = 1'b0;
    prog_run         = 1'b0;
    auto_inc         = 1'b0;
    botao_write      = 1'b1;
    botao_wipe       = 1'b1;
    switch_enderecos = '0;
    switch_dados     = '0;

    // Reset and idle
    step(3);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_we", 32'(ram_we), 32'd0);
    clear_n = 1'b1;
    step(3);
    check("idle_hold", 32'(cpu_hold), 32'd1);
    check("idle_we", 32'(ram_we), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_cnt", 32'(addr_count), 32'd0);
    check("idle_addr", 32'(ram_addr), 32'd0);
    check("idle_data", 32'(ram_data), 32'd0);

    // Manual write, latency to the strobe
    auto_inc = 1'b0;
    switch_enderecos = 4'hA;
    switch_dados = 8'h5C;
    base = wr_q.size();
    first = 0;
    botao_write = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      step(1);
      if (ram_we === 1'b1 && first == 0) first = e;
    end
    botao_write = 1'b1;
    step(10);
    check("man_edge", 32'(first), 32'd7);
    check("man_count", 32'(wr_q.size() - base), 32'd1);
    ent = (wr_q.size() > base) ? wr_q[base] : '1;
    check("man_entry", 32'(ent), 32'h0A5C);
    check("man_acnt", 32'(addr_count), 32'd0);

    // Auto-increment with wrap
    auto_inc = 1'b1;
    base = wr_q.size();
    for (int i = 1; i <= 17; i++) begin
      switch_dados = 8'(i);
      press(1'b0, 8, 10);
    end
    check("auto_count", 32'(wr_q.size() - base), 32'd17);
    for (int k = 0; k < 17; k++) begin
      ent = (wr_q.size() > base + k) ? wr_q[base + k] : '1;
      check($sformatf("auto_entry%0d", k), 32'(ent), 32'({4'(k % 16), 8'(k + 1)}));
    end
    check("auto_acnt", 32'(addr_count), 32'd1);

    // Bounce rejected, then a stable manual press
    auto_inc = 1'b0;
    switch_enderecos = 4'h3;
    switch_dados = 8'h77;
    base = wr_q.size();
    botao_write = 1'b0; step(3);
    botao_write = 1'b1; step(2);
    botao_write = 1'b0; step(3);
    botao_write = 1'b1; step(10);
    check("bounce_none", 32'(wr_q.size() - base), 32'd0);
    press(1'b0, 8, 10);
    check("bounce_one", 32'(wr_q.size() - base), 32'd1);
    ent = (wr_q.size() > base) ? wr_q[base] : '1;
    check("bounce_entry", 32'(ent), 32'h0377);
    check("bounce_acnt", 32'(addr_count), 32'd1);

    // Wipe sweep from addr_count = 7
    auto_inc = 1'b1;
    switch_dados = 8'hFF;
    for (int i = 0; i < 6; i++) press(1'b0, 8, 10);
    check("pre_wipe_acnt", 32'(addr_count), 32'd7);
    base = wr_q.size();
    rbase = run_q.size();
    bb = busy_bad;
    press(1'b1, 25, 10);
    check("wipe_count", 32'(wr_q.size() - base), 32'd16);
    check("wipe_runs", 32'(run_q.size() - rbase), 32'd1);
    check("wipe_runlen", 32'((run_q.size() > rbase) ? run_q[rbase] : 0), 32'd16);
    for (int k = 0; k < 16; k++) begin
      ent = (wr_q.size() > base + k) ? wr_q[base + k] : '1;
      check($sformatf("wipe_entry%0d", k), 32'(ent), 32'({4'(k), 8'h00}));
    end
    check("wipe_busy", 32'(busy_bad - bb), 32'd0);
    check("wipe_acnt", 32'(addr_count), 32'd0);

    // prog_run raised mid-wipe: sweep completes, then run
    base = wr_q.size();
    rbase = run_q.size();
    botao_wipe = 1'b0;
    step(12);
    check("mwipe_active", 32'(ram_we), 32'd1);
    prog_run = 1'b1;
    step(20);
    check("mwipe_count", 32'(wr_q.size() - base), 32'd16);
    check("mwipe_runlen", 32'((run_q.size() > rbase) ? run_q[rbase] : 0), 32'd16);
    check("mwipe_run", 32'(cpu_hold), 32'd0);
    botao_wipe = 1'b1;
    step(5);
    prog_run = 1'b0;
    step(2);
    check("runoff_e2", 32'(cpu_hold), 32'd0);
    step(1);
    check("runoff_e3", 32'(cpu_hold), 32'd1);
    step(10);
    check("runoff_nowr", 32'(wr_q.size() - base), 32'd16);

    // prog_run raised mid-debounce: no write, run after 3 edges
    auto_inc = 1'b0;
    base = wr_q.size();
    botao_write = 1'b0;
    step(3);
    prog_run = 1'b1;
    step(2);
    check("mdeb_e2", 32'(cpu_hold), 32'd1);
    step(1);
    check("mdeb_e3", 32'(cpu_hold), 32'd0);
    step(14);
    botao_write = 1'b1;
    step(10);
    check("mdeb_nowr", 32'(wr_q.size() - base), 32'd0);
    prog_run = 1'b0;
    step(5);
    check("mdeb_idle", 32'(cpu_hold), 32'd1);
    check("mdeb_busy", 32'(busy), 32'd0);

    // Reset in the middle of a wipe stops the strobes on that edge
    botao_wipe = 1'b0;
    step(10);
    check("rwipe_active", 32'(ram_we), 32'd1);
    clear_n = 1'b0;
    botao_wipe = 1'b1;
    step(1);
    check("rwipe_we", 32'(ram_we), 32'd0);
    check("rwipe_busy", 32'(busy), 32'd0);
    check("rwipe_acnt", 32'(addr_count), 32'd0);
    clear_n = 1'b1;
    base = wr_q.size();
    step(20);
    check("rwipe_nowr", 32'(wr_q.size() - base), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
